// File: rtl/fetch_unit.sv
// Instruction fetch requester: owns the PC, reads imem combinationally and
// queues {pc, instruction} pairs in a small prefetch FIFO for decode.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0100_0000,
    parameter int          FIFO_DEPTH = 4,
    parameter int          PTR_W      = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] imem_address,
    output logic        imem_read_write,
    output logic [31:0] imem_data_in,
    input  logic [31:0] imem_data_out,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_data,
    output logic        fetch_misaligned,
    output logic [31:0] fetch_count
);

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } fifo_entry_t;

    fifo_entry_t      storage [FIFO_DEPTH];
    logic [31:0]      pc;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;
    logic             pop;
    logic             fetch;
    logic             full;

    assign imem_address    = pc;
    assign imem_read_write = 1'b0;
    assign imem_data_in    = 32'h0;

    assign inst_valid = (count != '0);
    assign inst_pc    = storage[rd_ptr].pc;
    assign inst_data  = storage[rd_ptr].data;

    assign full  = (count == DEPTH_C);
    assign pop   = inst_valid & inst_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign fetch = !reset & !redirect_valid & !halt & !fetch_misaligned & (!full | pop);

    always_ff @(posedge clock) begin
        if (reset) begin
            pc               <= RESET_PC;
            rd_ptr           <= '0;
            wr_ptr           <= '0;
            count            <= '0;
            fetch_misaligned <= 1'b0;
            fetch_count      <= 32'h0;
        end else if (redirect_valid) begin
            // Flush drops any concurrent pop; the target is word-aligned for fetch.
            pc               <= {redirect_pc[31:2], 2'b00};
            rd_ptr           <= '0;
            wr_ptr           <= '0;
            count            <= '0;
            fetch_misaligned <= (redirect_pc[1:0] != 2'b00);
        end else begin
            if (fetch) begin
                storage[wr_ptr] <= '{pc: pc, data: imem_data_out};
                wr_ptr          <= wr_ptr + 1'b1;
                pc              <= pc + 32'd4;
                fetch_count     <= fetch_count + 32'd1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (fetch && !pop)
                count <= count + 1'b1;
            else if (pop && !fetch)
                count <= count - 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, streaming, backpressure, redirect,
// misaligned redirect, halt, PC wrap and reset priority.
module tb_fetch_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] imem_address;
    logic        imem_read_write;
    logic [31:0] imem_data_in;
    logic [31:0] imem_data_out;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_pc;
    logic [31:0] inst_data;
    logic        fetch_misaligned;
    logic [31:0] fetch_count;

    int checks = 0;
    int failures = 0;

    localparam logic [31:0] BASE = 32'h0100_0000;

    fetch_unit #(.RESET_PC(BASE), .FIFO_DEPTH(4), .PTR_W(2)) dut (
        .clock(clock), .reset(reset),
        .imem_address(imem_address), .imem_read_write(imem_read_write),
        .imem_data_in(imem_data_in), .imem_data_out(imem_data_out),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_pc(inst_pc), .inst_data(inst_data),
        .fetch_misaligned(fetch_misaligned), .fetch_count(fetch_count)
    );

    always #5 clock = ~clock;

    // Instruction memory model: three program words, then an address-derived pattern.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0100_0000: return 32'h0000_0013;
            32'h0100_0004: return 32'h0010_0093;
            32'h0100_0008: return 32'h0020_0113;
            default:       return a ^ 32'h5A5A_0000;
        endcase
    endfunction

    assign imem_data_out = mem_word(imem_address);

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input logic rdy);
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; halt = 1'b0;
        inst_ready = rdy;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(1'b1);
        reset = 1'b1;
        tick();
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", inst_valid); end
        checks++; if (fetch_count !== 32'h0) begin failures++; $display("FAIL reset_count got=%h exp=0", fetch_count); end
        checks++; if (imem_address !== BASE) begin failures++; $display("FAIL reset_pc got=%h exp=%h", imem_address, BASE); end
        checks++; if (fetch_misaligned !== 1'b0) begin failures++; $display("FAIL reset_misaligned got=%0b exp=0", fetch_misaligned); end
        checks++; if ({imem_read_write, imem_data_in} !== 33'h0) begin failures++; $display("FAIL reset_rw got=%0b/%h exp=0/0", imem_read_write, imem_data_in); end
        reset = 1'b0;
    endtask

    task automatic test_stream();
        // reset was just released in test_reset; nothing fetched yet
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL stream_pre_valid got=%0b exp=0", inst_valid); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (inst_valid !== 1'b1 || inst_pc !== BASE + 32'(4*i) || inst_data !== mem_word(BASE + 32'(4*i)))
                begin failures++; $display("FAIL stream_head%0d got=%0b/%h/%h exp=1/%h/%h", i, inst_valid, inst_pc, inst_data, BASE + 32'(4*i), mem_word(BASE + 32'(4*i))); end
        end
        checks++; if (fetch_count !== 32'd3) begin failures++; $display("FAIL stream_count got=%0d exp=3", fetch_count); end
    endtask

    task automatic test_backpressure();
        do_reset(1'b0);
        for (int i = 0; i < 10; i++) tick();
        checks++; if (imem_address !== 32'h0100_0010) begin failures++; $display("FAIL bp_addr got=%h exp=01000010", imem_address); end
        checks++; if (fetch_count !== 32'd4) begin failures++; $display("FAIL bp_count got=%0d exp=4", fetch_count); end
        inst_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (inst_valid !== 1'b1 || inst_pc !== BASE + 32'(4*i) || inst_data !== mem_word(BASE + 32'(4*i)))
                begin failures++; $display("FAIL bp_drain%0d got=%0b/%h/%h exp=1/%h/%h", i, inst_valid, inst_pc, inst_data, BASE + 32'(4*i), mem_word(BASE + 32'(4*i))); end
            tick();
        end
        // every drain cycle also pushed while full
        checks++; if (fetch_count !== 32'd8 || inst_pc !== 32'h0100_0010) begin failures++; $display("FAIL bp_full_push got=%0d/%h exp=8/01000010", fetch_count, inst_pc); end
    endtask

    task automatic test_redirect();
        do_reset(1'b0);
        tick(); tick(); tick();
        checks++; if (fetch_count !== 32'd3) begin failures++; $display("FAIL redir_setup got=%0d exp=3", fetch_count); end
        inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0100_0040;
        tick();
        redirect_valid = 1'b0;
        checks++; if (inst_valid !== 1'b0 || imem_address !== 32'h0100_0040 || fetch_count !== 32'd3)
            begin failures++; $display("FAIL redir_flush got=%0b/%h/%0d exp=0/01000040/3", inst_valid, imem_address, fetch_count); end
        tick();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0100_0040 || inst_data !== 32'h5B5A_0040)
            begin failures++; $display("FAIL redir_target got=%0b/%h/%h exp=1/01000040/5b5a0040", inst_valid, inst_pc, inst_data); end
    endtask

    task automatic test_misaligned();
        logic [31:0] fc;
        redirect_valid = 1'b1; redirect_pc = 32'h0100_0042;
        tick();
        redirect_valid = 1'b0;
        fc = fetch_count;
        checks++; if (fetch_misaligned !== 1'b1 || imem_address !== 32'h0100_0040)
            begin failures++; $display("FAIL mis_set got=%0b/%h exp=1/01000040", fetch_misaligned, imem_address); end
        tick(); tick(); tick();
        checks++; if (fetch_count !== fc || inst_valid !== 1'b0 || fetch_misaligned !== 1'b1)
            begin failures++; $display("FAIL mis_frozen got=%0d/%0b/%0b exp=%0d/0/1", fetch_count, inst_valid, fetch_misaligned, fc); end
        redirect_valid = 1'b1; redirect_pc = 32'h0100_0080;
        tick();
        redirect_valid = 1'b0;
        checks++; if (fetch_misaligned !== 1'b0 || imem_address !== 32'h0100_0080)
            begin failures++; $display("FAIL mis_clear got=%0b/%h exp=0/01000080", fetch_misaligned, imem_address); end
        tick();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0100_0080 || fetch_count !== fc + 32'd1)
            begin failures++; $display("FAIL mis_resume got=%0b/%h/%0d exp=1/01000080/%0d", inst_valid, inst_pc, fetch_count, fc + 32'd1); end
    endtask

    task automatic test_halt();
        do_reset(1'b0);
        tick(); tick();
        halt = 1'b1; inst_ready = 1'b1;
        checks++; if (inst_pc !== BASE) begin failures++; $display("FAIL halt_head0 got=%h exp=%h", inst_pc, BASE); end
        tick();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0100_0004) begin failures++; $display("FAIL halt_head1 got=%0b/%h exp=1/01000004", inst_valid, inst_pc); end
        for (int i = 0; i < 4; i++) tick();
        checks++; if (inst_valid !== 1'b0 || imem_address !== 32'h0100_0008 || fetch_count !== 32'd2)
            begin failures++; $display("FAIL halt_drained got=%0b/%h/%0d exp=0/01000008/2", inst_valid, imem_address, fetch_count); end
        halt = 1'b0;
        tick();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0100_0008 || inst_data !== 32'h0020_0113)
            begin failures++; $display("FAIL halt_resume got=%0b/%h/%h exp=1/01000008/00200113", inst_valid, inst_pc, inst_data); end
    endtask

    task automatic test_pc_wrap();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        tick();
        checks++; if (inst_pc !== 32'hFFFF_FFFC || imem_address !== 32'h0) begin failures++; $display("FAIL pc_wrap got=%h/%h exp=fffffffc/00000000", inst_pc, imem_address); end
    endtask

    task automatic test_reset_priority();
        redirect_valid = 1'b1; redirect_pc = 32'h0100_0046;
        tick();
        checks++; if (fetch_misaligned !== 1'b1) begin failures++; $display("FAIL rp_setup got=%0b exp=1", fetch_misaligned); end
        reset = 1'b1; halt = 1'b1;
        tick();
        reset = 1'b0; redirect_valid = 1'b0; halt = 1'b0;
        checks++; if (imem_address !== BASE || inst_valid !== 1'b0 || fetch_count !== 32'h0 || fetch_misaligned !== 1'b0)
            begin failures++; $display("FAIL rp_state got=%h/%0b/%0d/%0b exp=%h/0/0/0", imem_address, inst_valid, fetch_count, fetch_misaligned, BASE); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_misaligned();
        test_halt();
        test_pc_wrap();
        test_reset_priority();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
